// File: rtl/usr_deframer.sv
// rtl/usr_deframer.sv - serial-to-parallel deframer: sync hunt, word assembly, even-parity check
// Good words are offered on a valid/ready port; a busy slot drops the new word and flags overflow.
module usr_deframer #(
  parameter int                   DATA_BITS    = 4,
  parameter int                   SYNC_BITS    = 4,
  parameter logic [SYNC_BITS-1:0] SYNC_PATTERN = 4'b1011,
  parameter int                   ERR_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 sin_valid,
  input  logic                 sin_bit,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 locked,
  output logic                 parity_err,
  output logic                 overflow,
  output logic [ERR_W-1:0]     err_count
);

  localparam logic [1:0] S_HUNT     = 2'd0;
  localparam logic [1:0] S_DATA     = 2'd1;
  localparam logic [1:0] S_PARITY   = 2'd2;
  localparam logic [1:0] S_SYNC_CHK = 2'd3;

  localparam int FILL_W = $clog2(SYNC_BITS + 1);
  localparam int BCNT_W = $clog2(DATA_BITS + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_BITS);
  localparam logic [FILL_W-1:0] SYNC_LAST = FILL_W'(SYNC_BITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  logic [1:0]           r_state;
  logic [SYNC_BITS-1:0] r_window;
  logic [FILL_W-1:0]    r_fill;
  logic [FILL_W-1:0]    r_sync_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [BCNT_W-1:0]    r_bit_cnt;
  logic                 r_out_valid;
  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_locked;
  logic                 r_parity_err;
  logic                 r_overflow;
  logic [ERR_W-1:0]     r_err_count;

  logic [SYNC_BITS-1:0] w_window_nxt;
  logic [FILL_W-1:0]    w_fill_nxt;
  logic                 w_hunt_hit;
  logic [SYNC_BITS-1:0] w_exp_pat;
  logic                 w_sync_ok;
  logic                 w_par_good;
  logic                 w_new_word;
  logic                 w_xfer;

  assign w_window_nxt = {r_window[SYNC_BITS-2:0], sin_bit};
  assign w_fill_nxt   = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
  assign w_hunt_hit   = (w_fill_nxt == FILL_FULL) && (w_window_nxt == SYNC_PATTERN);
  // Expected sync bit is the pattern MSB after discarding the bits already matched.
  assign w_exp_pat    = SYNC_PATTERN << r_sync_cnt;
  assign w_sync_ok    = (sin_bit == w_exp_pat[SYNC_BITS-1]);
  assign w_par_good   = ~^{r_shreg, sin_bit};
  assign w_new_word   = sin_valid && (r_state == S_PARITY) && w_par_good;
  assign w_xfer       = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_HUNT;
      r_window     <= '0;
      r_fill       <= '0;
      r_sync_cnt   <= '0;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_locked     <= 1'b0;
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
      r_err_count  <= '0;
    end else if (clear) begin
      r_state      <= S_HUNT;
      r_window     <= '0;
      r_fill       <= '0;
      r_sync_cnt   <= '0;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_locked     <= 1'b0;
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
      if (sin_valid) begin
        case (r_state)
          S_HUNT: begin
            r_window <= w_window_nxt;
            r_fill   <= w_fill_nxt;
            if (w_hunt_hit) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              r_locked  <= 1'b1;
            end
          end
          S_DATA: begin
            r_shreg <= {r_shreg[DATA_BITS-2:0], sin_bit};
            if (r_bit_cnt == BCNT_LAST) begin
              r_state <= S_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
            end
          end
          S_PARITY: begin
            r_state    <= S_SYNC_CHK;
            r_sync_cnt <= '0;
            if (!w_par_good) begin
              r_parity_err <= 1'b1;
              if (r_err_count != ERR_MAX) begin
                r_err_count <= r_err_count + ERR_W'(1);
              end
            end
          end
          default: begin
            // The window keeps tracking so a failed re-sync can resume hunting with a full window.
            r_window <= w_window_nxt;
            if (!w_sync_ok) begin
              r_state  <= S_HUNT;
              r_locked <= 1'b0;
              r_fill   <= FILL_FULL;
            end else if (r_sync_cnt == SYNC_LAST) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_sync_cnt <= r_sync_cnt + FILL_W'(1);
            end
          end
        endcase
      end
      if (w_new_word) begin
        if (!r_out_valid || out_ready) begin
          r_out_data  <= r_shreg;
          r_out_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign locked     = r_locked;
  assign parity_err = r_parity_err;
  assign overflow   = r_overflow;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_usr_deframer.sv
// tb/tb_usr_deframer.sv - self-checking bench for usr_deframer
// Directed scenarios plus a randomized stream compared against a frame-position reference model.
module tb_usr_deframer;

  logic       clk = 1'b0;
  logic       reset, clear, sin_valid, sin_bit, out_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       locked, parity_err, overflow;
  logic [7:0] err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usr_deframer #(
    .DATA_BITS(4), .SYNC_BITS(4), .SYNC_PATTERN(4'b1011), .ERR_W(8)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .locked(locked),
    .parity_err(parity_err), .overflow(overflow), .err_count(err_count)
  );

  logic [15:0] dut_vec;
  assign dut_vec = {out_valid, out_data, locked, parity_err, overflow, err_count};

  // Reference model: m_pos is the position inside a frame (-1 hunting, 0..3 payload, 4 parity, 5..8 sync slot).
  bit       m_valid, m_locked, m_perr, m_ovf;
  bit [3:0] m_data, m_word;
  int       m_err, m_pos;
  bit       hist[$];
  bit [3:0] pat = 4'b1011;

  function automatic logic [15:0] m_vec();
    return {m_valid, m_data, m_locked, m_perr, m_ovf, 8'(m_err)};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_locked = 0; m_perr = 0; m_ovf = 0;
    m_data = 0; m_word = 0; m_err = 0; m_pos = -1;
    hist.delete();
  endtask

  task automatic model_edge(input bit v, input bit b, input bit r);
    bit xfer;
    bit newword;
    xfer = m_valid && r;
    newword = 0;
    m_perr = 0;
    m_ovf = 0;
    if (v) begin
      if (m_pos < 0 || m_pos >= 5) begin
        hist.push_back(b);
        if (hist.size() > 4) hist.delete(0);
      end
      if (m_pos < 0) begin
        if (hist.size() == 4 && {hist[0], hist[1], hist[2], hist[3]} == pat) begin
          m_pos = 0;
          m_locked = 1;
        end
      end else if (m_pos < 4) begin
        m_word = {m_word[2:0], b};
        m_pos++;
      end else if (m_pos == 4) begin
        if ((($countones(m_word) + int'(b)) % 2) == 0) newword = 1;
        else begin
          m_perr = 1;
          if (m_err < 255) m_err++;
        end
        m_pos = 5;
      end else begin
        if (b != pat[3 - (m_pos - 5)]) begin
          m_pos = -1;
          m_locked = 0;
        end else begin
          m_pos++;
          if (m_pos == 9) m_pos = 0;
        end
      end
    end
    if (newword) begin
      if (!m_valid || r) begin
        m_data = m_word;
        m_valid = 1;
      end else m_ovf = 1;
    end else if (xfer) m_valid = 0;
  endtask

  task automatic cyc(input bit v, input bit b, input bit r);
    sin_valid = v;
    sin_bit   = b;
    out_ready = r;
    @(posedge clk);
    if (clear) model_reset();
    else model_edge(v, b, r);
    #1;
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input bit r);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], r);
  endtask

  task automatic do_reset();
    reset = 1'b0; clear = 1'b0; sin_valid = 1'b0; sin_bit = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; sin_valid = 1'b1; sin_bit = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (dut_vec !== 16'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0000", dut_vec); end
    reset = 1'b1;
    model_reset();
    cyc(1'b0, 1'b0, 1'b1);
    n_cmp++; if (dut_vec !== 16'h0) begin n_fail++; $display("FAIL reset_idle: got %h want 0000", dut_vec); end
  endtask

  task automatic test_clean_frame();
    do_reset();
    feed(32'b1011_0110_0, 9, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 4'h6) begin n_fail++; $display("FAIL clean_data: got %h want 6", out_data); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL clean_locked: got %b want 1", locked); end
    n_cmp++; if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL clean_model: got %h want %h", dut_vec, m_vec()); end
    cyc(1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_bad_parity();
    do_reset();
    feed(32'b1011_0110_1, 9, 1'b1);
    n_cmp++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL perr_pulse: got %b want 1", parity_err); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL perr_count: got %0d want 1", err_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL perr_valid: got %b want 0", out_valid); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL perr_locked: got %b want 1", locked); end
    cyc(1'b0, 1'b0, 1'b1);
    n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL perr_one_cycle: got %b want 0", parity_err); end
    // Sync slot accepted back-to-back confirms the FSM went to the sync check.
    feed(32'b1011_1001_0, 9, 1'b1);
    n_cmp++; if ({out_valid, out_data} !== 5'h19) begin n_fail++; $display("FAIL perr_next_word: got %h want 19", {out_valid, out_data}); end
  endtask

  task automatic test_overflow();
    do_reset();
    feed(32'b1011_0110_0, 9, 1'b0);
    n_cmp++; if ({out_valid, out_data} !== 5'h16) begin n_fail++; $display("FAIL ovf_first: got %h want 16", {out_valid, out_data}); end
    feed(32'b1011_0011, 8, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    n_cmp++; if ({out_valid, out_data} !== 5'h16) begin n_fail++; $display("FAIL ovf_held: got %h want 16", {out_valid, out_data}); end
    cyc(1'b0, 1'b0, 1'b1);
    n_cmp++; if ({out_valid, overflow} !== 2'b00) begin n_fail++; $display("FAIL ovf_drain: got %b want 00", {out_valid, overflow}); end
    n_cmp++; if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL ovf_model: got %h want %h", dut_vec, m_vec()); end
  endtask

  task automatic test_noise_lock_loss();
    do_reset();
    feed(32'b000101, 6, 1'b1);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL noise_nolock: got %b want 0", locked); end
    cyc(1'b1, 1'b1, 1'b1);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL noise_lock: got %b want 1", locked); end
    feed(32'b1001_0, 5, 1'b1);
    n_cmp++; if ({out_valid, out_data} !== 5'h19) begin n_fail++; $display("FAIL noise_word: got %h want 19", {out_valid, out_data}); end
    cyc(1'b1, 1'b0, 1'b1);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL noise_unlock: got %b want 0", locked); end
    feed(32'b000, 3, 1'b1);
    n_cmp++; if ({locked, out_valid} !== 2'b00) begin n_fail++; $display("FAIL noise_tail: got %b want 00", {locked, out_valid}); end
    n_cmp++; if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL noise_model: got %h want %h", dut_vec, m_vec()); end
  endtask

  task automatic test_gapped();
    logic [8:0] fr;
    fr = 9'b1011_1111_0;
    do_reset();
    for (int i = 8; i >= 0; i--) begin
      cyc(1'b1, fr[i], 1'b0);
      if (i != 0) cyc(1'b0, ~fr[i], 1'b0);
    end
    n_cmp++; if ({out_valid, out_data} !== 5'h1F) begin n_fail++; $display("FAIL gap_word: got %h want 1f", {out_valid, out_data}); end
    n_cmp++; if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL gap_model: got %h want %h", dut_vec, m_vec()); end
  endtask

  task automatic test_reset_clear_mid();
    do_reset();
    feed(32'b1011_0110_0, 9, 1'b0);
    feed(32'b1011_01, 6, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (dut_vec !== 16'h0) begin n_fail++; $display("FAIL midreset_zero: got %h want 0000", dut_vec); end
    model_reset();
    reset = 1'b1;
    feed(32'b1011_1010_0, 9, 1'b1);
    n_cmp++; if ({out_valid, out_data} !== 5'h1A) begin n_fail++; $display("FAIL midreset_word: got %h want 1a", {out_valid, out_data}); end
    feed(32'b1011_0110_0, 9, 1'b0);
    feed(32'b1011_01, 6, 1'b0);
    clear = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    clear = 1'b0;
    n_cmp++; if (dut_vec !== 16'h0) begin n_fail++; $display("FAIL midclear_zero: got %h want 0000", dut_vec); end
    feed(32'b1011_1010_0, 9, 1'b1);
    n_cmp++; if ({out_valid, out_data} !== 5'h1A) begin n_fail++; $display("FAIL midclear_word: got %h want 1a", {out_valid, out_data}); end
  endtask

  task automatic test_err_saturation();
    int want;
    do_reset();
    for (int f = 0; f < 300; f++) begin
      feed(32'b1011_0110_1, 9, 1'b1);
      want = (f + 1 > 255) ? 255 : f + 1;
      n_cmp++; if (err_count !== 8'(want)) begin n_fail++; $display("FAIL err_sat frame %0d: got %0d want %0d", f, err_count, want); end
    end
  endtask

  task automatic test_random();
    bit   bq[$];
    bit   [3:0] s, d;
    bit   par;
    int   gaps;
    do_reset();
    for (int f = 0; f < 400; f++) begin
      bq.delete();
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 5)) bq.push_back(bit'($urandom_range(0, 1)));
      s = pat;
      if ($urandom_range(0, 7) == 0) s[$urandom_range(0, 3)] ^= 1'b1;
      d = 4'($urandom);
      par = ^d;
      if ($urandom_range(0, 3) == 0) par = ~par;
      for (int k = 3; k >= 0; k--) bq.push_back(s[k]);
      for (int k = 3; k >= 0; k--) bq.push_back(d[k]);
      bq.push_back(par);
      for (int i = 0; i < bq.size(); i++) begin
        gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        for (int g = 0; g <= gaps; g++) begin
          clear = ($urandom_range(0, 499) == 0);
          cyc(g == gaps, (g == gaps) ? bq[i] : bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
          clear = 1'b0;
          n_cmp++;
          if (dut_vec !== m_vec()) begin
            n_fail++;
            $display("FAIL random frame %0d: got %h want %h", f, dut_vec, m_vec());
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_bad_parity();
    test_overflow();
    test_noise_lock_loss();
    test_gapped();
    test_reset_clear_mid();
    test_err_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
